// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: pipeline writeback port, multicycle-unit
// port and the registered register-file write port.
interface regfile_write_arbiter_if;
  logic        WbWrite_i;
  logic [4:0]  WbReg_i;
  logic [31:0] WbData_i;
  logic        WbStall_o;

  logic        McValid_i;
  logic [4:0]  McReg_i;
  logic [31:0] McData_i;
  logic        McReady_o;

  logic        RegWrite_o;
  logic [4:0]  WriteRegister_o;
  logic [31:0] WriteData_o;
  logic        Busy_o;

  // Arbiter side
  modport slave (
    input  WbWrite_i, WbReg_i, WbData_i, McValid_i, McReg_i, McData_i,
    output WbStall_o, McReady_o, RegWrite_o, WriteRegister_o, WriteData_o, Busy_o
  );

  // Requester / environment side
  modport master (
    output WbWrite_i, WbReg_i, WbData_i, McValid_i, McReg_i, McData_i,
    input  WbStall_o, McReady_o, RegWrite_o, WriteRegister_o, WriteData_o, Busy_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and a multicycle unit. After reset it can zero-fill all 32
// registers, then grants Wb by priority with a starvation escape for Mc.
module regfile_write_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned STARVE_LIMIT   = 4      // legal 1..15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q;
  logic [3:0]  starve_q;
  logic        starve;
  logic        wb_valid;
  logic        wb_grant;
  logic        mc_xfer;
  logic        wb_stall;
  logic        mc_ready;
  logic        busy;

  logic        reg_write_q;
  logic [4:0]  write_reg_q;
  logic [31:0] write_data_q;

  assign starve   = (starve_q == LIMIT);
  assign wb_valid = bus.WbWrite_i && (bus.WbReg_i != 5'd0);

  // Next state and handshake outputs; McReady is a function of state and Wb
  // only, never of McValid, so the Mc side sees no combinational loop.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    wb_stall = 1'b1;
    mc_ready = 1'b0;
    busy     = 1'b0;
    if (!rst_i) begin
      case (state_q)
        CLEAR: begin
          busy = 1'b1;
          if (clr_idx_q == 5'd31) state_d = RUN;
        end
        RUN: begin
          if (starve) begin
            wb_stall = 1'b1;
            mc_ready = 1'b1;
          end else if (wb_valid) begin
            wb_stall = 1'b0;
            mc_ready = 1'b0;
          end else begin
            wb_stall = 1'b0;
            mc_ready = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign wb_grant = !rst_i && (state_q == RUN) && !starve && wb_valid;
  assign mc_xfer  = bus.McValid_i && mc_ready;

  // FSM state and zero-fill index.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_idx_q <= 5'd0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_idx_q <= clr_idx_q + 5'd1;
    end
  end

  // Starve counter: counts refused Mc cycles, saturating; any transfer or
  // idle Mc cycle restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else if (mc_xfer || !bus.McValid_i) begin
      starve_q <= 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  // Registered write port: zero-fill in CLEAR, otherwise the granted request.
  // Address/data hold when no write issues; r0 transfers write nothing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else if (state_q == CLEAR) begin
      reg_write_q  <= 1'b1;
      write_reg_q  <= clr_idx_q;
      write_data_q <= 32'd0;
    end else if (wb_grant) begin
      reg_write_q  <= 1'b1;
      write_reg_q  <= bus.WbReg_i;
      write_data_q <= bus.WbData_i;
    end else if (mc_xfer && (bus.McReg_i != 5'd0)) begin
      reg_write_q  <= 1'b1;
      write_reg_q  <= bus.McReg_i;
      write_data_q <= bus.McData_i;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  assign bus.WbStall_o       = wb_stall;
  assign bus.McReady_o       = mc_ready;
  assign bus.Busy_o          = busy;
  assign bus.RegWrite_o      = reg_write_q;
  assign bus.WriteRegister_o = write_reg_q;
  assign bus.WriteData_o     = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model
// that also keeps a shadow register file.
module tb_regfile_write_arbiter;

  localparam bit CLR   = 1'b1;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .CLEAR_ON_RESET (CLR),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit          m_clearing;
  int          m_pos;
  int          m_starve;
  bit          e_we;
  logic [4:0]  e_reg;
  logic [31:0] e_data;
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];
  int          dut_clear_writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check handshake outputs before the edge,
  // advance the model, check the registered write port after the edge.
  task automatic step(input bit r, input bit wbw, input logic [4:0] wbr,
                      input logic [31:0] wbd, input bit mcv,
                      input logic [4:0] mcr, input logic [31:0] mcd);
    bit x_stall, x_ready, x_busy, force_mc, wbv, xfer;
    @(negedge clk);
    rst = r;
    bus.WbWrite_i = wbw; bus.WbReg_i = wbr; bus.WbData_i = wbd;
    bus.McValid_i = mcv; bus.McReg_i = mcr; bus.McData_i = mcd;
    #1;
    force_mc = (m_starve == LIMIT);
    wbv      = wbw && (wbr != 5'd0);
    if (r) begin
      x_stall = 1; x_ready = 0; x_busy = 0;
    end else if (m_clearing) begin
      x_stall = 1; x_ready = 0; x_busy = 1;
    end else if (force_mc) begin
      x_stall = 1; x_ready = 1; x_busy = 0;
    end else if (wbv) begin
      x_stall = 0; x_ready = 0; x_busy = 0;
    end else begin
      x_stall = 0; x_ready = 1; x_busy = 0;
    end
    check("wb_stall", 32'(bus.WbStall_o), 32'(x_stall));
    check("mc_ready", 32'(bus.McReady_o), 32'(x_ready));
    check("busy",     32'(bus.Busy_o),    32'(x_busy));

    xfer = mcv && x_ready;
    if (r) begin
      e_we = 0; e_reg = '0; e_data = '0;
      m_starve = 0; m_clearing = CLR; m_pos = 0;
    end else begin
      if (m_clearing) begin
        e_we = 1; e_reg = 5'(m_pos); e_data = '0;
        m_pos++;
        if (m_pos == 32) m_clearing = 0;
      end else if (!force_mc && wbv) begin
        e_we = 1; e_reg = wbr; e_data = wbd;
      end else if (xfer && mcr != 5'd0) begin
        e_we = 1; e_reg = mcr; e_data = mcd;
      end else begin
        e_we = 0;
      end
      if (xfer || !mcv) m_starve = 0;
      else if (m_starve < 15) m_starve++;
      if (e_we) rf_model[e_reg] = e_data;
    end

    @(posedge clk);
    #1;
    check("reg_write",  32'(bus.RegWrite_o),      32'(e_we));
    check("write_reg",  32'(bus.WriteRegister_o), 32'(e_reg));
    check("write_data", bus.WriteData_o,          e_data);
    if (bus.RegWrite_o === 1'b1) rf_dut[bus.WriteRegister_o] = bus.WriteData_o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    bus.WbWrite_i = 0; bus.WbReg_i = '0; bus.WbData_i = '0;
    bus.McValid_i = 0; bus.McReg_i = '0; bus.McData_i = '0;
    m_clearing = 0; m_pos = 0; m_starve = 0;
    e_we = 0; e_reg = '0; e_data = '0;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = 32'hFFFF_FFFF;
      rf_dut[i]   = 32'hFFFF_FFFF;
    end

    // Reset, then the full zero-fill and the drop of Busy.
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(32);
    idle(2);

    // Collision: Wb r5 and Mc r7 together, Wb idle next cycle.
    step(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd7, 32'h12345678);
    step(0, 0, 5'd0, 32'd0,        1, 5'd7, 32'h12345678);
    idle(2);

    // Starvation: Wb valid every cycle, Mc held; forced through on cycle 5,
    // then the counter restarts and Mc is refused again.
    for (int i = 0; i < 8; i++)
      step(0, 1, 5'(1 + i), 32'(32'hA000_0000 + i), 1, 5'd9, 32'hC0FFEE00);
    idle(2);

    // Register 0: Wb to r0 writes nothing, Mc to r0 handshakes with no write.
    step(0, 1, 5'd0, 32'h1111_1111, 0, 5'd0, 32'd0);
    step(0, 0, 5'd0, 32'd0,         1, 5'd0, 32'h2222_2222);
    // Wb to r0 alongside Mc: Mc gets the port.
    step(0, 1, 5'd0, 32'h3333_3333, 1, 5'd3, 32'h4444_4444);
    idle(1);

    // Reset mid-clear at index 17, then count the restarted zero-fill.
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    idle(17);
    step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    dut_clear_writes = 0;
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      if (bus.RegWrite_o === 1'b1 && bus.WriteRegister_o == 5'(i) && bus.WriteData_o == 32'd0)
        dut_clear_writes++;
    end
    check("clear_restart_writes", 32'(dut_clear_writes), 32'd32);
    idle(1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      logic [4:0]  wr, mr;
      r  = ($urandom_range(0, 299) == 0);
      wr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      mr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      step(r, 1'($urandom_range(0, 3) != 0), wr, $urandom,
           1'($urandom_range(0, 2) != 0), mr, $urandom);
    end
    idle(3);

    // Shadow register file built from the write port vs the model's.
    for (int i = 0; i < 32; i++)
      check($sformatf("rf[%0d]", i), rf_dut[i], rf_model[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, SHALL select a 32-cycle zero-fill of the register file after reset (1) or go straight to arbitration (0).
REQ-002 Parameter STARVE_LIMIT, default 4, legal 1..15, SHALL set the number of refused multicycle-request cycles before that requester is forced through.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 WbWrite_i  in  1  SHALL be the pipeline writeback write request.
REQ-006 WbReg_i  in  5 / WbData_i  in  32  SHALL be the writeback destination and data.
REQ-007 WbStall_o  out  1  SHALL tell the pipeline to hold writeback; while high, the block ignores the Wb inputs.
REQ-008 McValid_i  in  1 / McReg_i  in  5 / McData_i  in  32  SHALL be the multicycle-unit write request: valid, destination, data.
REQ-009 McReady_o  out  1  SHALL accept the Mc request; a transfer occurs when McValid_i and McReady_o are both high at a rising edge.
REQ-010 RegWrite_o  out  1 / WriteRegister_o  out  5 / WriteData_o  out  32  SHALL drive the register-file write port; all three are registered.
REQ-011 Busy_o  out  1  SHALL be high while in state CLEAR.

Function
REQ-012 The FSM SHALL have exactly two states, CLEAR and RUN.
REQ-013 CLEAR SHALL use a 5-bit index counting 0..31, one step per cycle, and produce a write of 0x00000000 to the current index each cycle.
REQ-014 After the cycle that writes index 31, the FSM SHALL enter RUN; RUN persists until reset.
REQ-015 In CLEAR, WbStall_o SHALL be 1 and McReady_o SHALL be 0.
REQ-016 A Wb request SHALL be valid only if WbWrite_i=1 and WbReg_i!=0.
REQ-017 RUN grant priority, evaluated each cycle:
  - starve flag set: Mc wins; WbStall_o=1; McReady_o=1.
  - else valid Wb request: Wb wins; WbStall_o=0; McReady_o=0.
  - else: WbStall_o=0; McReady_o=1.
REQ-018 McReady_o SHALL NOT depend combinationally on McValid_i.
REQ-019 A 4-bit starve counter SHALL:
  - increment, saturating, on each cycle with McValid_i=1 and McReady_o=0;
  - clear to 0 on any Mc transfer or any cycle with McValid_i=0.
REQ-020 The starve flag SHALL be (starve counter == STARVE_LIMIT).
REQ-021 A granted write SHALL appear on RegWrite_o/WriteRegister_o/WriteData_o exactly 1 cycle after its grant cycle.
REQ-022 In every cycle with no granted write, RegWrite_o SHALL be 0, and WriteRegister_o/WriteData_o SHALL hold their previous values.
REQ-023 An Mc transfer with McReg_i=0 SHALL complete the handshake, clear the starve counter and produce no write.
REQ-024 If WbReg_i=0 and McValid_i=1 in the same cycle, Mc SHALL be granted, because the Wb request is not valid.
REQ-025 At most one write SHALL be issued per cycle; no request SHALL be dropped except writes to register 0.

Reset
REQ-026 While rst_i=1: WbStall_o=1, McReady_o=0, Busy_o=0.
REQ-027 At a rising edge with rst_i=1: RegWrite_o=0, WriteRegister_o=0, WriteData_o=0, starve counter=0, clear index=0.
REQ-028 After reset the FSM SHALL be in CLEAR if CLEAR_ON_RESET=1, otherwise in RUN.
REQ-029 Reset asserted mid-CLEAR SHALL restart the zero-fill at index 0.
REQ-030 Reset asserted in RUN SHALL discard any pending grant; no write SHALL issue on the following cycle.

Verification
REQ-031 Zero-fill: CLEAR_ON_RESET=1, rst_i high 1 cycle then released -> 32 consecutive cycles of RegWrite_o=1 with WriteRegister_o 0..31 and WriteData_o=0; Busy_o=1 and WbStall_o=1 throughout; then Busy_o=0 and RegWrite_o=0.
REQ-032 Collision: in RUN, Wb r5=0xDEADBEEF and Mc r7=0x12345678 in the same cycle, Wb idle on the next cycle -> r5 write 1 cycle later, McReady_o=0 on the first cycle; the Mc transfer completes on the second cycle; the r7 write follows 1 cycle after that.
REQ-033 Starvation: STARVE_LIMIT=4, valid Wb every cycle, McValid_i held high -> McReady_o=0 for 4 cycles; on the 5th cycle McReady_o=1 and WbStall_o=1; Mc write 1 cycle later; counter returns to 0.
REQ-034 Register 0: WbWrite_i=1 with WbReg_i=0 and Mc idle -> RegWrite_o stays 0; Mc request to r0 -> handshake completes with RegWrite_o=0.
REQ-035 Reset mid-clear: rst_i pulsed while the clear index is 17 -> zero-fill restarts at 0; 32 full writes occur before Busy_o falls.
